sump_sample_tx: RTL

//  Transmit path of logIP: serialises captured sample words onto the UART tx line.

---
 rtl/sump_sample_tx_pkg.sv | 19 +
 rtl/sump_sample_tx_uart_tx_byte.sv | 86 ++++++++
 rtl/sump_sample_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sump_sample_tx_pkg.sv
// Package logip_pkg: shared constants and types for the logIP UART transmit path.
//   UART_DATA_BITS  : data bits per UART character
//   UART_FRAME_BITS : start + data + stop bits per character
//   UART_START/STOP : line levels of the start and stop bits
//   tx_state_e      : word-sequencer states (IDLE, SEND, DROP)
package logip_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;
  localparam logic UART_START      = 1'b0;
  localparam logic UART_STOP       = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sump_sample_tx_uart_tx_byte.sv
// uart_tx_byte: serialises one byte as 8N1 (start, d0..d7 LSB first, stop).
//   clk_i        : system clock
//   rst_in       : asynchronous active-low reset
//   byte_i       : byte to send, taken when byte_valid_i && byte_ready_o
//   byte_valid_i : byte_i is valid
//   byte_ready_o : idle, or in the last cycle of the stop bit (allows
//                  back-to-back characters with no idle gap)
//   tx_o         : serial line, driven straight from a flop, idle high
module uart_tx_byte
  import logip_pkg::*;
#(
  parameter int CLK_PER_BIT = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_in,
  input  logic [UART_DATA_BITS-1:0] byte_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  output logic                      tx_o
);

  localparam int                BAUD_W   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [3:0]        BIT_STOP = 4'(UART_FRAME_BITS - 1);
  localparam logic [3:0]        BIT_D7   = 4'(UART_FRAME_BITS - 2);

  logic                      active_q, active_d;
  logic                      tx_q, tx_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [3:0]                bit_q, bit_d;   // 0 = start, 1..8 = d0..d7, 9 = stop
  logic                      bit_end;
  logic                      load;

  assign bit_end      = active_q && (baud_q == BAUD_MAX);
  assign byte_ready_o = !active_q || (bit_end && (bit_q == BIT_STOP));
  assign load         = byte_valid_i && byte_ready_o;
  assign tx_o         = tx_q;

  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    data_d   = data_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    if (load) begin
      // Start bit goes out in the cycle right after the loading edge.
      active_d = 1'b1;
      tx_d     = UART_START;
      data_d   = byte_i;
      baud_d   = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == BIT_STOP) begin
          active_d = 1'b0;
          tx_d     = UART_STOP;
        end else begin
          bit_d = bit_q + 4'd1;
          // Entering bit bit_q+1: data bit bit_q, or the stop bit after d7.
          tx_d  = (bit_q == BIT_D7) ? UART_STOP : data_q[bit_q[2:0]];
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      active_q <= 1'b0;
      tx_q     <= UART_STOP;
      data_q   <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      data_q   <= data_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: rtl/sump_sample_tx.sv
// sump_sample_tx: transmit path of logIP. Latches a WIDTH-bit sample word and
// sends its enabled bytes (LSB byte first) as back-to-back 8N1 characters.
//   clk_i    : system clock
//   rst_in   : asynchronous active-low reset
//   data_i   : sample word to transmit
//   valid_i  : data_i / grp_en_i valid
//   ready_o  : word can be accepted this cycle (registered, high only in IDLE)
//   grp_en_i : per-byte enable, bit k sends data_i[8k+7:8k]
//   tx_o     : UART serial output, idle high
//   busy_o   : word in progress (state is not IDLE)
module sump_sample_tx
  import logip_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CLK_PER_BIT = 10
) (
  input  logic               clk_i,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH/8-1:0] grp_en_i,
  output logic               tx_o,
  output logic               busy_o
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  tx_state_e          state_q;
  logic               ready_q;
  logic               busy_q;
  logic [WIDTH-1:0]   word_q;
  logic [NB-1:0]      mask_q;

  logic [7:0]         word_bytes [NB];
  logic [7:0]         in_bytes   [NB];
  logic [IDX_W-1:0]   cur_idx;
  logic [NB-1:0]      mask_clr;
  logic               accept;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               byte_done;

  // Lowest set bit wins: bytes go out LSB group first.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NB-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bytes
      assign word_bytes[gi] = word_q[8*gi +: 8];
      assign in_bytes[gi]   = data_i[8*gi +: 8];
    end
  endgenerate

  assign accept    = valid_i && ready_q;
  assign cur_idx   = lowest_idx(mask_q);
  assign mask_clr  = mask_q & ~(NB'(1) << cur_idx);
  // In SEND the serialiser is always active, so ready means the stop bit ends now.
  assign byte_done = (state_q == SEND) && byte_ready;

  // The first byte is handed to the serialiser on the accepting edge itself
  // (straight from data_i) so the start bit appears one cycle later. Later
  // bytes are offered from word_q and taken at the end of the previous stop bit.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (accept && (grp_en_i != '0)) begin
          byte_valid = 1'b1;
          byte_data  = in_bytes[lowest_idx(grp_en_i)];
        end
      end
      SEND: begin
        if (mask_clr != '0) begin
          byte_valid = 1'b1;
          byte_data  = word_bytes[lowest_idx(mask_clr)];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      word_q  <= '0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q  <= data_i;
            mask_q  <= grp_en_i;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (grp_en_i != '0) ? SEND : DROP;
          end
        end
        SEND: begin
          if (byte_done) begin
            mask_q <= mask_clr;
            if (mask_clr == '0) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        DROP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          mask_q  <= '0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;

  uart_tx_byte #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_uart_tx_byte (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .byte_i      (byte_data),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .tx_o        (tx_o)
  );

endmodule
